// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit for the 5-stage MIPS pipeline: per-GPR ready counters, MDU busy tracking, forwarding selects.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module hazard_scoreboard #(
  parameter int unsigned REG_NUM  = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned MDU_LAT  = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic              UseRsD,
  input  logic              UseRtD,
  input  logic              EarlyD,
  input  logic              RegWriteD,
  input  logic [REG_AW-1:0] WriteRegD,
  input  logic              MemReadD,
  input  logic              MduStartD,
  input  logic              HiLoReadD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              GoHandlerM,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic [1:0]        ForwardAD,
  output logic [1:0]        ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MduBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       PerfRegStall,
  output logic [31:0]       PerfMduStall,
  output logic [31:0]       PerfFlush
`endif
);

  localparam int unsigned CW = $clog2(LOAD_LAT + 1);
  typedef logic [CW-1:0] cnt_t;

  cnt_t       cnt_q [REG_NUM-1:1];
  cnt_t       cnt_d [REG_NUM-1:1];
  logic [7:0] mdu_cnt_q, mdu_cnt_d;

  cnt_t rs_cnt, rt_cnt;
  logic rs_stall, rt_stall, regstall, mdustall, stall;
  logic issue, mdu_issue, mdu_busy;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              wr_m,
    input logic [REG_AW-1:0] reg_m,
    input logic              wr_w,
    input logic [REG_AW-1:0] reg_w
  );
    if (wr_m && (reg_m != '0) && (reg_m == src))      return 2'b10;
    else if (wr_w && (reg_w != '0) && (reg_w == src)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Register 0 has no counter, so its lookup stays at zero and never stalls.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      if (RsD == REG_AW'(r)) rs_cnt = cnt_q[r];
      if (RtD == REG_AW'(r)) rt_cnt = cnt_q[r];
    end
  end

  // Early consumers need the value one cycle sooner, so they wait until the count fully drains.
  always_comb begin
    rs_stall  = UseRsD & (EarlyD ? (rs_cnt != '0) : (rs_cnt > cnt_t'(1)));
    rt_stall  = UseRtD & (EarlyD ? (rt_cnt != '0) : (rt_cnt > cnt_t'(1)));
    regstall  = rs_stall | rt_stall;
    mdu_busy  = (mdu_cnt_q != '0);
    mdustall  = (MduStartD | HiLoReadD) & mdu_busy;
    stall     = regstall | mdustall;
    issue     = RegWriteD & (WriteRegD != '0) & ~stall & ~GoHandlerM;
    mdu_issue = MduStartD & ~stall & ~GoHandlerM;
  end

  always_comb begin
    for (int unsigned r = 1; r < REG_NUM; r++) begin
      cnt_d[r] = cnt_q[r];
      if (GoHandlerM)
        cnt_d[r] = '0;
      else if (issue && (WriteRegD == REG_AW'(r)))
        cnt_d[r] = MemReadD ? cnt_t'(LOAD_LAT) : cnt_t'(1);
      else if (cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - cnt_t'(1);
    end
  end

  always_comb begin
    mdu_cnt_d = mdu_cnt_q;
    if (GoHandlerM)
      mdu_cnt_d = '0;
    else if (mdu_issue)
      mdu_cnt_d = 8'(MDU_LAT);
    else if (mdu_busy)
      mdu_cnt_d = mdu_cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned r = 1; r < REG_NUM; r++) cnt_q[r] <= '0;
      mdu_cnt_q <= '0;
    end else begin
      for (int unsigned r = 1; r < REG_NUM; r++) cnt_q[r] <= cnt_d[r];
      mdu_cnt_q <= mdu_cnt_d;
    end
  end

  // Every output is forced low while reset is held, including the combinational forward selects.
  always_comb begin
    StallF    = resetn & stall & ~GoHandlerM;
    StallD    = resetn & stall & ~GoHandlerM;
    FlushE    = resetn & (stall | GoHandlerM);
    FlushD    = resetn & GoHandlerM;
    FlushM    = resetn & GoHandlerM;
    FlushW    = resetn & GoHandlerM;
    MduBusy   = resetn & mdu_busy;
    ForwardAD = resetn ? fwd_sel(RsD, RegWriteM, WriteRegM, RegWriteW, WriteRegW) : 2'b00;
    ForwardBD = resetn ? fwd_sel(RtD, RegWriteM, WriteRegM, RegWriteW, WriteRegW) : 2'b00;
    ForwardAE = resetn ? fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW) : 2'b00;
    ForwardBE = resetn ? fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW) : 2'b00;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_reg_q, perf_reg_d;
  logic [31:0] perf_mdu_q, perf_mdu_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_reg_d   = perf_reg_q;
    perf_mdu_d   = perf_mdu_q;
    perf_flush_d = perf_flush_q;
    if (regstall && (perf_reg_q != '1))               perf_reg_d   = perf_reg_q + 32'd1;
    if (mdustall && !regstall && (perf_mdu_q != '1))  perf_mdu_d   = perf_mdu_q + 32'd1;
    if (GoHandlerM && (perf_flush_q != '1))           perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_reg_q   <= '0;
      perf_mdu_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_reg_q   <= perf_reg_d;
      perf_mdu_q   <= perf_mdu_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  always_comb begin
    PerfRegStall = perf_reg_q;
    PerfMduStall = perf_mdu_q;
    PerfFlush    = perf_flush_q;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed hazard scenarios plus randomized traffic against a ready-time model.
module tb_hazard_scoreboard;
  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned MDU_LAT  = 32;

  logic       clk, resetn;
  logic [4:0] RsD, RtD, WriteRegD, RsE, RtE, WriteRegM, WriteRegW;
  logic       UseRsD, UseRtD, EarlyD, RegWriteD, MemReadD, MduStartD, HiLoReadD;
  logic       RegWriteM, RegWriteW, GoHandlerM;
  logic       StallF, StallD, FlushD, FlushE, FlushM, FlushW, MduBusy;
  logic [1:0] ForwardAD, ForwardBD, ForwardAE, ForwardBE;

  hazard_scoreboard #(.REG_NUM(32), .REG_AW(5), .LOAD_LAT(LOAD_LAT), .MDU_LAT(MDU_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD), .EarlyD(EarlyD),
    .RegWriteD(RegWriteD), .WriteRegD(WriteRegD), .MemReadD(MemReadD),
    .MduStartD(MduStartD), .HiLoReadD(HiLoReadD), .RsE(RsE), .RtE(RtE),
    .RegWriteM(RegWriteM), .WriteRegM(WriteRegM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .GoHandlerM(GoHandlerM), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduBusy(MduBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 10;

  // Model state: cycle at which each register's result becomes visible on the W path, and MDU completion cycle.
  int rdy [32];
  int mdu_done;
  logic        e_stall_raw;
  logic [14:0] e_vec;
  logic [14:0] o_vec;
  assign o_vec = {StallF, StallD, FlushD, FlushE, FlushM, FlushW,
                  ForwardAD, ForwardBD, ForwardAE, ForwardBE, MduBusy};

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (RegWriteM && WriteRegM != 5'd0 && WriteRegM == src) return 2'b10;
    if (RegWriteW && WriteRegW != 5'd0 && WriteRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit src_waits(input logic use_bit, input logic [4:0] r);
    if (!use_bit || r == 5'd0) return 1'b0;
    return EarlyD ? (cyc <= rdy[r]) : (cyc < rdy[r]);
  endfunction

  task automatic model_eval();
    logic regs, busy, mdus, hold;
    regs = src_waits(UseRsD, RsD) | src_waits(UseRtD, RtD);
    busy = (cyc < mdu_done);
    mdus = (MduStartD | HiLoReadD) & busy;
    e_stall_raw = regs | mdus;
    hold = e_stall_raw & ~GoHandlerM;
    if (!resetn) e_vec = '0;
    else e_vec = {hold, hold, GoHandlerM, e_stall_raw | GoHandlerM, GoHandlerM, GoHandlerM,
                  ref_fwd(RsD), ref_fwd(RtD), ref_fwd(RsE), ref_fwd(RtE), busy};
  endtask

  task automatic model_commit();
    if (!resetn || GoHandlerM) begin
      for (int i = 0; i < 32; i++) rdy[i] = 0;
      mdu_done = 0;
    end else if (!e_stall_raw) begin
      if (RegWriteD && WriteRegD != 5'd0)
        rdy[WriteRegD] = cyc + (MemReadD ? int'(LOAD_LAT) : 1);
      if (MduStartD) mdu_done = cyc + int'(MDU_LAT) + 1;
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    RsD = '0; RtD = '0; UseRsD = 0; UseRtD = 0; EarlyD = 0; RegWriteD = 0; WriteRegD = '0;
    MemReadD = 0; MduStartD = 0; HiLoReadD = 0; RsE = '0; RtE = '0;
    RegWriteM = 0; WriteRegM = '0; RegWriteW = 0; WriteRegW = '0; GoHandlerM = 0;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [4:0] rreg();
    int unsigned k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  task automatic rand_inputs();
    RsD = rreg(); RtD = rreg(); WriteRegD = rreg(); RsE = rreg(); RtE = rreg();
    WriteRegM = rreg(); WriteRegW = rreg();
    UseRsD = 1'($urandom_range(0, 1)); UseRtD = 1'($urandom_range(0, 1));
    EarlyD = ($urandom_range(0, 3) == 0); RegWriteD = 1'($urandom_range(0, 1));
    MemReadD = 1'($urandom_range(0, 1)); MduStartD = ($urandom_range(0, 29) == 0);
    HiLoReadD = ($urandom_range(0, 7) == 0); RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1)); GoHandlerM = ($urandom_range(0, 39) == 0);
  endtask

  // Holds the current decode inputs until StallD drops; leaves the releasing cycle un-ticked.
  task automatic hold_until_go(output int n, output bit flush_ok, output bit timed_out);
    n = 0; flush_ok = 1'b1; timed_out = 1'b1;
    for (int i = 0; i < 64; i++) begin
      settle();
      if (StallD !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      if (FlushE !== 1'b1 || StallF !== 1'b1) flush_ok = 1'b0;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      settle();
      checks++;
      if (o_vec !== 15'd0) begin
        errors++; $display("FAIL reset_outputs: got %h expected 0000", o_vec);
      end
      tick();
    end
    resetn = 1'b1;
    idle();
    UseRsD = 1; UseRtD = 1; EarlyD = 1; RsD = 5'd9; RtD = 5'd31;
    settle();
    checks++;
    if (o_vec !== 15'd0) begin
      errors++; $display("FAIL post_reset_idle: got %h expected 0000", o_vec);
    end
    tick();
  endtask

  task automatic test_alu_to_alu();
    drain(3);
    RegWriteD = 1; WriteRegD = 5'd8;
    tick();
    idle();
    UseRsD = 1; RsD = 5'd8; RegWriteD = 1; WriteRegD = 5'd10;
    settle();
    checks++;
    if (StallD !== 1'b0) begin
      errors++; $display("FAIL alu_alu_stall: got %b expected 0", StallD);
    end
    tick();
    idle();
    RsE = 5'd8; RtE = 5'd8; RegWriteM = 1; WriteRegM = 5'd8; RegWriteW = 1; WriteRegW = 5'd8;
    settle();
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
      errors++; $display("FAIL alu_alu_fwd_m_priority: got %b/%b expected 10/10", ForwardAE, ForwardBE);
    end
    tick();
  endtask

  task automatic test_load_use();
    int n; bit fok, tmo;
    drain(3);
    RegWriteD = 1; MemReadD = 1; WriteRegD = 5'd9;
    tick();
    idle();
    UseRsD = 1; RsD = 5'd9; RegWriteD = 1; WriteRegD = 5'd11;
    hold_until_go(n, fok, tmo);
    checks++;
    if (tmo) begin errors++; $display("FAIL load_use_timeout: stall never released"); end
    checks++;
    if (n != int'(LOAD_LAT) - 1) begin
      errors++; $display("FAIL load_use_stalls: got %0d expected %0d", n, int'(LOAD_LAT) - 1);
    end
    checks++;
    if (!fok) begin errors++; $display("FAIL load_use_flushE: FlushE/StallF not high during stall"); end
    tick();
    idle();
    RsE = 5'd9; RegWriteW = 1; WriteRegW = 5'd9;
    settle();
    checks++;
    if (ForwardAE !== 2'b01) begin
      errors++; $display("FAIL load_use_fwd_w: got %b expected 01", ForwardAE);
    end
    tick();
  endtask

  task automatic test_load_branch();
    int n; bit fok, tmo;
    drain(3);
    RegWriteD = 1; MemReadD = 1; WriteRegD = 5'd9;
    tick();
    idle();
    EarlyD = 1; UseRsD = 1; RsD = 5'd9; UseRtD = 1; RtD = 5'd0;
    hold_until_go(n, fok, tmo);
    checks++;
    if (tmo || n != int'(LOAD_LAT)) begin
      errors++; $display("FAIL load_branch_stalls: got %0d (timeout %0d) expected %0d", n, tmo, LOAD_LAT);
    end
    RegWriteW = 1; WriteRegW = 5'd9; RegWriteM = 1; WriteRegM = 5'd0;
    settle();
    checks++;
    if (ForwardAD !== 2'b01 || ForwardBD !== 2'b00) begin
      errors++; $display("FAIL load_branch_fwd: got %b/%b expected 01/00", ForwardAD, ForwardBD);
    end
    tick();
  endtask

  task automatic test_alu_branch();
    int n; bit fok, tmo;
    drain(3);
    RegWriteD = 1; WriteRegD = 5'd12;
    tick();
    idle();
    EarlyD = 1; UseRtD = 1; RtD = 5'd12;
    hold_until_go(n, fok, tmo);
    checks++;
    if (tmo || n != 1) begin
      errors++; $display("FAIL alu_branch_stalls: got %0d (timeout %0d) expected 1", n, tmo);
    end
    tick();
  endtask

  task automatic test_mdu();
    int n, busy_cnt; bit fok, tmo;
    drain(3);
    MduStartD = 1;
    tick();
    idle();
    for (int i = 1; i < 4; i++) tick();
    HiLoReadD = 1;
    hold_until_go(n, fok, tmo);
    checks++;
    if (tmo || n != int'(MDU_LAT) + 1 - 4) begin
      errors++; $display("FAIL mdu_mflo_stalls: got %0d (timeout %0d) expected %0d", n, tmo, int'(MDU_LAT) - 3);
    end
    tick();
    drain(2);
    MduStartD = 1;
    tick();
    idle();
    busy_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      settle();
      if (MduBusy !== 1'b1) break;
      busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != int'(MDU_LAT)) begin
      errors++; $display("FAIL mdu_busy_cycles: got %0d expected %0d", busy_cnt, MDU_LAT);
    end
    tick();
  endtask

  task automatic test_exception();
    drain(3);
    MduStartD = 1;
    tick();
    idle();
    for (int i = 0; i < 11; i++) tick();
    RegWriteD = 1; MemReadD = 1; WriteRegD = 5'd9;
    tick();
    idle();
    GoHandlerM = 1; UseRsD = 1; RsD = 5'd9; EarlyD = 1;
    settle();
    checks++;
    if ({FlushD, FlushE, FlushM, FlushW, StallF, StallD} !== 6'b111100) begin
      errors++; $display("FAIL exc_flush: got %b expected 111100",
                         {FlushD, FlushE, FlushM, FlushW, StallF, StallD});
    end
    tick();
    idle();
    UseRsD = 1; RsD = 5'd9; EarlyD = 1; HiLoReadD = 1;
    settle();
    checks++;
    if (StallD !== 1'b0 || MduBusy !== 1'b0) begin
      errors++; $display("FAIL exc_cleared: StallD=%b MduBusy=%b expected 0/0", StallD, MduBusy);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drain(3);
    RegWriteD = 1; MemReadD = 1; WriteRegD = 5'd9;
    tick();
    idle();
    UseRsD = 1; RsD = 5'd9; EarlyD = 1;
    settle();
    checks++;
    if (StallD !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: StallD=%b expected 1", StallD); end
    tick();
    resetn = 1'b0;
    settle();
    checks++;
    if (o_vec !== 15'd0) begin errors++; $display("FAIL rst_mid_outputs: got %h expected 0000", o_vec); end
    tick();
    resetn = 1'b1;
    settle();
    checks++;
    if (StallD !== 1'b0) begin errors++; $display("FAIL rst_mid_release: StallD=%b expected 0", StallD); end
    tick();
  endtask

  task automatic test_random();
    drain(40);
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      resetn = ($urandom_range(0, 199) != 0);
      settle();
      checks++;
      if (o_vec !== e_vec) begin
        errors++; $display("FAIL random_cycle_%0d: got %h expected %h", i, o_vec, e_vec);
      end
      tick();
    end
    resetn = 1'b1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rdy[i] = 0;
    mdu_done = 0;
    idle();
    test_reset();
    test_alu_to_alu();
    test_load_use();
    test_load_branch();
    test_alu_branch();
    test_mdu();
    test_exception();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end
endmodule
